// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: op codes, FSM
// state encoding and default bank geometry.
package mem_ctrl_pkg;

  localparam int unsigned MEM_DATA_W = 8;
  localparam int unsigned MEM_ADDR_W = 5;
  localparam int unsigned BANK_DEPTH = 1 << MEM_ADDR_W;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/mem_xfer_counter.sv
// Byte index, remaining-byte count and read-latency wait counter used by the
// access controller to sequence multi-byte copy/fill transfers.
module mem_xfer_counter #(
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned WAIT_W    = 1,
  parameter int unsigned WAIT_INIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [IDX_W-1:0]  i_len,
  input  logic              i_step,
  input  logic              i_wait_load,
  input  logic              i_wait_dec,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_last_c,
  output logic              o_wait_done_c
);

  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_rem;
  logic [WAIT_W-1:0] r_wait;

  // Index/remaining advance together, one step per completed byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx  <= '0;
      r_rem  <= '0;
      r_wait <= '0;
    end else begin
      if (i_load) begin
        r_idx <= '0;
        r_rem <= i_len;
      end else if (i_step) begin
        r_idx <= r_idx + IDX_W'(1);
        r_rem <= r_rem - IDX_W'(1);
      end
      if (i_wait_load) begin
        r_wait <= WAIT_W'(WAIT_INIT);
      end else if (i_wait_dec && (r_wait != '0)) begin
        r_wait <= r_wait - WAIT_W'(1);
      end
    end
  end

  assign o_idx         = r_idx;
  assign o_last_c      = (r_rem == IDX_W'(1));
  assign o_wait_done_c = (r_wait == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the data-memory port: accepts load/store/copy/fill
// requests and sequences the bank's read/write cycles, one response each.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = MEM_DATA_W,
  parameter int unsigned ADDR_W   = MEM_ADDR_W,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_src,
  input  logic [ADDR_W:0]   req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [ADDR_W-1:0] mem_addr_in,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              r_w
);

  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  logic [1:0]        r_state;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;
  logic              r_busy;
  logic [ADDR_W-1:0] r_mem_addr_out;
  logic [ADDR_W-1:0] r_mem_addr_in;
  logic [DATA_W-1:0] r_mem_data_in;
  logic              r_rw;

  logic [1:0]        w_state_nxt;
  logic [1:0]        w_op_nxt;
  logic [ADDR_W-1:0] w_src_nxt;
  logic [ADDR_W-1:0] w_dst_nxt;
  logic              w_ready_nxt;
  logic              w_valid_nxt;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic              w_err_nxt;
  logic [ADDR_W-1:0] w_addr_out_nxt;
  logic [ADDR_W-1:0] w_addr_in_nxt;
  logic [DATA_W-1:0] w_data_in_nxt;
  logic              w_rw_nxt;
  logic              w_cnt_load;
  logic              w_cnt_step;
  logic              w_wait_load;
  logic              w_wait_dec;
  logic [LEN_W-1:0]  w_idx;
  logic [LEN_W-1:0]  w_idx_inc;
  logic              w_last;
  logic              w_wait_done;
  logic              w_len_ok;

  mem_xfer_counter #(
    .IDX_W     (LEN_W),
    .WAIT_W    (WAIT_W),
    .WAIT_INIT (READ_LAT - 1)
  ) u_xfer_counter (
    .clk           (clk),
    .reset         (reset),
    .i_load        (w_cnt_load),
    .i_len         (req_len),
    .i_step        (w_cnt_step),
    .i_wait_load   (w_wait_load),
    .i_wait_dec    (w_wait_dec),
    .o_idx         (w_idx),
    .o_last_c      (w_last),
    .o_wait_done_c (w_wait_done)
  );

  assign w_len_ok  = (req_len != '0) && (req_len <= LEN_W'(DEPTH));
  assign w_idx_inc = w_idx + LEN_W'(1);

  // Next state plus the next value of every registered output.
  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_src_nxt      = r_src;
    w_dst_nxt      = r_dst;
    w_ready_nxt    = 1'b0;
    w_valid_nxt    = 1'b0;
    w_rdata_nxt    = r_resp_rdata;
    w_err_nxt      = r_resp_err;
    w_addr_out_nxt = r_mem_addr_out;
    w_addr_in_nxt  = r_mem_addr_in;
    w_data_in_nxt  = r_mem_data_in;
    w_rw_nxt       = 1'b1;
    w_cnt_load     = 1'b0;
    w_cnt_step     = 1'b0;
    w_wait_load    = 1'b0;
    w_wait_dec     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_ready_nxt = 1'b1;
        if (req_valid) begin
          w_ready_nxt = 1'b0;
          w_op_nxt    = req_op;
          w_src_nxt   = req_src;
          w_dst_nxt   = req_addr;
          case (req_op)
            OP_LOAD: begin
              w_state_nxt    = ST_RD;
              w_wait_load    = 1'b1;
              w_addr_out_nxt = req_addr;
            end
            OP_STORE: begin
              w_state_nxt   = ST_WR;
              w_addr_in_nxt = req_addr;
              w_data_in_nxt = req_wdata;
              w_rw_nxt      = 1'b0;
            end
            default: begin
              if (!w_len_ok) begin
                w_state_nxt = ST_RESP;
                w_valid_nxt = 1'b1;
                w_err_nxt   = 1'b1;
                w_rdata_nxt = '0;
              end else begin
                w_cnt_load = 1'b1;
                if (req_op == OP_COPY) begin
                  w_state_nxt    = ST_RD;
                  w_wait_load    = 1'b1;
                  w_addr_out_nxt = req_src;
                end else begin
                  w_state_nxt   = ST_WR;
                  w_addr_in_nxt = req_addr;
                  w_data_in_nxt = req_wdata;
                  w_rw_nxt      = 1'b0;
                end
              end
            end
          endcase
        end
      end

      ST_RD: begin
        if (!w_wait_done) begin
          w_wait_dec = 1'b1;
        end else if (r_op == OP_LOAD) begin
          w_state_nxt = ST_RESP;
          w_valid_nxt = 1'b1;
          w_err_nxt   = 1'b0;
          w_rdata_nxt = mem_data_out;
        end else begin
          w_state_nxt   = ST_WR;
          w_addr_in_nxt = r_dst + ADDR_W'(w_idx);
          w_data_in_nxt = mem_data_out;
          w_rw_nxt      = 1'b0;
        end
      end

      // The byte just written is what copy/fill/store report back.
      ST_WR: begin
        if ((r_op == OP_STORE) || w_last) begin
          w_state_nxt = ST_RESP;
          w_valid_nxt = 1'b1;
          w_err_nxt   = 1'b0;
          w_rdata_nxt = r_mem_data_in;
        end else begin
          w_cnt_step = 1'b1;
          if (r_op == OP_COPY) begin
            w_state_nxt    = ST_RD;
            w_wait_load    = 1'b1;
            w_addr_out_nxt = r_src + ADDR_W'(w_idx_inc);
          end else begin
            w_state_nxt   = ST_WR;
            w_addr_in_nxt = r_dst + ADDR_W'(w_idx_inc);
            w_rw_nxt      = 1'b0;
          end
        end
      end

      ST_RESP: begin
        w_state_nxt = ST_IDLE;
        w_ready_nxt = 1'b1;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_op           <= OP_LOAD;
      r_src          <= '0;
      r_dst          <= '0;
      r_req_ready    <= 1'b1;
      r_resp_valid   <= 1'b0;
      r_resp_rdata   <= '0;
      r_resp_err     <= 1'b0;
      r_busy         <= 1'b0;
      r_mem_addr_out <= '0;
      r_mem_addr_in  <= '0;
      r_mem_data_in  <= '0;
      r_rw           <= 1'b1;
    end else begin
      r_state        <= w_state_nxt;
      r_op           <= w_op_nxt;
      r_src          <= w_src_nxt;
      r_dst          <= w_dst_nxt;
      r_req_ready    <= w_ready_nxt;
      r_resp_valid   <= w_valid_nxt;
      r_resp_rdata   <= w_rdata_nxt;
      r_resp_err     <= w_err_nxt;
      r_busy         <= (w_state_nxt != ST_IDLE);
      r_mem_addr_out <= w_addr_out_nxt;
      r_mem_addr_in  <= w_addr_in_nxt;
      r_mem_data_in  <= w_data_in_nxt;
      r_rw           <= w_rw_nxt;
    end
  end

  assign req_ready    = r_req_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_resp_rdata;
  assign resp_err     = r_resp_err;
  assign busy         = r_busy;
  assign mem_addr_out = r_mem_addr_out;
  assign mem_addr_in  = r_mem_addr_in;
  assign mem_data_in  = r_mem_data_in;
  assign r_w          = r_rw;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a 32x8 bank model that writes
// whenever r_w is low.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 5;
  localparam int unsigned RL = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [AW-1:0] req_src = '0;
  logic [AW:0]   req_len = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          busy;
  logic [AW-1:0] mem_addr_out;
  logic [AW-1:0] mem_addr_in;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic          r_w;

  logic [DW-1:0] bank [32];
  logic [DW-1:0] exp_bank [32];
  int            wr_cnt;
  logic          tb_clr = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         lat;
    logic       err;
    logic [7:0] rdata;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .READ_LAT (RL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_src      (req_src),
    .req_len      (req_len),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .busy         (busy),
    .mem_addr_out (mem_addr_out),
    .mem_addr_in  (mem_addr_in),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .r_w          (r_w)
  );

  // Bank model: synchronous write while r_w is low, asynchronous read.
  always_ff @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 32; i++) bank[i] <= '0;
      wr_cnt <= 0;
    end else if (r_w == 1'b0) begin
      bank[mem_addr_in] <= mem_data_in;
      wr_cnt <= wr_cnt + 1;
    end
  end
  assign mem_data_out = bank[mem_addr_out];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int bank_diffs();
    int d = 0;
    for (int i = 0; i < 32; i++) if (bank[i] !== exp_bank[i]) d++;
    return d;
  endfunction

  task automatic send_req(input logic [1:0] op, input logic [4:0] addr, input logic [4:0] src,
                          input logic [5:0] len, input logic [7:0] wd, output logic rdy);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_src = src; req_len = len; req_wdata = wd;
    rdy = req_ready;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Measures cycles from the accept edge to resp_valid; lat=-1 on timeout.
  task automatic wait_resp(output int lat, output logic err, output logic [7:0] rd,
                           output logic busy_ok);
    bit done = 0;
    lat = 0; err = 1'b0; rd = '0; busy_ok = 1'b1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (resp_valid === 1'b1) begin
        done = 1; err = resp_err; rd = resp_rdata;
      end else if (busy !== 1'b1 || req_ready !== 1'b0) begin
        busy_ok = 1'b0;
      end
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; tb_clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; tb_clr = 1'b0;
    for (int i = 0; i < 32; i++) exp_bank[i] = '0;
    @(negedge clk);
    n_vec++;
    if ({r_w, resp_valid, req_ready, busy, resp_err} !== 5'b10100) begin
      n_err++;
      $display("FAIL reset_ctrl: got rw/vld/rdy/busy/err=%b required 10100",
               {r_w, resp_valid, req_ready, busy, resp_err});
    end
    n_vec++;
    if ({resp_rdata, mem_addr_out, mem_addr_in, mem_data_in} !== '0) begin
      n_err++;
      $display("FAIL reset_data: rdata=%h aout=%h ain=%h din=%h required all 0",
               resp_rdata, mem_addr_out, mem_addr_in, mem_data_in);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (wr_cnt !== 0) begin
      n_err++;
      $display("FAIL reset_no_write: got %0d bank writes required 0", wr_cnt);
    end
  endtask

  task automatic test_store_load();
    int lat; logic err; logic [7:0] rd; logic bok; logic rdy; exp_t e;
    sb.push_back('{2, 1'b0, 8'hA5});
    exp_bank[3] = 8'hA5;
    send_req(OP_STORE, 5'd3, 5'd0, 6'd0, 8'hA5, rdy);
    wait_resp(lat, err, rd, bok);
    e = sb.pop_front();
    n_vec++;
    if (lat !== e.lat || err !== e.err || rd !== e.rdata || bok !== 1'b1) begin
      n_err++;
      $display("FAIL store: lat=%0d err=%b rdata=%h busy_ok=%b required lat=%0d err=%b rdata=%h busy_ok=1",
               lat, err, rd, bok, e.lat, e.err, e.rdata);
    end
    sb.push_back('{RL + 1, 1'b0, 8'hA5});
    send_req(OP_LOAD, 5'd3, 5'd9, 6'd0, 8'h00, rdy);
    wait_resp(lat, err, rd, bok);
    e = sb.pop_front();
    n_vec++;
    if (lat !== e.lat || err !== e.err || rd !== e.rdata) begin
      n_err++;
      $display("FAIL load: lat=%0d err=%b rdata=%h required lat=%0d err=%b rdata=%h",
               lat, err, rd, e.lat, e.err, e.rdata);
    end
  endtask

  task automatic test_fill_wrap();
    int lat; logic err; logic [7:0] rd; logic bok; logic rdy; exp_t e; int d;
    sb.push_back('{5, 1'b0, 8'h5C});
    exp_bank[30] = 8'h5C; exp_bank[31] = 8'h5C; exp_bank[0] = 8'h5C; exp_bank[1] = 8'h5C;
    send_req(OP_FILL, 5'd30, 5'd0, 6'd4, 8'h5C, rdy);
    wait_resp(lat, err, rd, bok);
    e = sb.pop_front();
    n_vec++;
    if (lat !== e.lat || err !== e.err || rd !== e.rdata || bok !== 1'b1) begin
      n_err++;
      $display("FAIL fill_wrap: lat=%0d err=%b rdata=%h busy_ok=%b required lat=%0d err=%b rdata=%h busy_ok=1",
               lat, err, rd, bok, e.lat, e.err, e.rdata);
    end
    d = bank_diffs();
    n_vec++;
    if (d != 0) begin
      n_err++;
      $display("FAIL fill_wrap_bank: %0d bank bytes differ, required 0 (bank[0]=%h bank[31]=%h)",
               d, bank[0], bank[31]);
    end
  endtask

  task automatic test_copy();
    int lat; logic err; logic [7:0] rd; logic bok; logic rdy; exp_t e; int d;
    logic [7:0] pre [3];
    pre[0] = 8'h11; pre[1] = 8'h22; pre[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{2, 1'b0, pre[i]});
      exp_bank[i] = pre[i];
      send_req(OP_STORE, 5'(i), 5'd0, 6'd0, pre[i], rdy);
      wait_resp(lat, err, rd, bok);
      e = sb.pop_front();
      n_vec++;
      if (lat !== e.lat || rd !== e.rdata) begin
        n_err++;
        $display("FAIL copy_preload%0d: lat=%0d rdata=%h required lat=%0d rdata=%h",
                 i, lat, rd, e.lat, e.rdata);
      end
    end
    sb.push_back('{3 * (RL + 1) + 1, 1'b0, 8'h33});
    for (int i = 0; i < 3; i++) exp_bank[8 + i] = pre[i];
    send_req(OP_COPY, 5'd8, 5'd0, 6'd3, 8'hEE, rdy);
    wait_resp(lat, err, rd, bok);
    e = sb.pop_front();
    n_vec++;
    if (lat !== e.lat || err !== e.err || rd !== e.rdata || bok !== 1'b1) begin
      n_err++;
      $display("FAIL copy: lat=%0d err=%b rdata=%h busy_ok=%b required lat=%0d err=%b rdata=%h busy_ok=1",
               lat, err, rd, bok, e.lat, e.err, e.rdata);
    end
    d = bank_diffs();
    n_vec++;
    if (d != 0) begin
      n_err++;
      $display("FAIL copy_bank: %0d bytes differ required 0 (bank[8..10]=%h %h %h)",
               d, bank[8], bank[9], bank[10]);
    end
  endtask

  task automatic test_len_err();
    int lat; logic err; logic [7:0] rd; logic bok; logic rdy; exp_t e; int w0; int d;
    w0 = wr_cnt;
    sb.push_back('{1, 1'b1, 8'h00});
    send_req(OP_COPY, 5'd12, 5'd0, 6'd0, 8'h44, rdy);
    wait_resp(lat, err, rd, bok);
    e = sb.pop_front();
    n_vec++;
    if (lat !== e.lat || err !== e.err) begin
      n_err++;
      $display("FAIL copy_len0: lat=%0d err=%b required lat=%0d err=%b", lat, err, e.lat, e.err);
    end
    sb.push_back('{1, 1'b1, 8'h00});
    send_req(OP_FILL, 5'd12, 5'd0, 6'd33, 8'h44, rdy);
    wait_resp(lat, err, rd, bok);
    e = sb.pop_front();
    n_vec++;
    if (lat !== e.lat || err !== e.err) begin
      n_err++;
      $display("FAIL fill_len33: lat=%0d err=%b required lat=%0d err=%b", lat, err, e.lat, e.err);
    end
    repeat (2) @(negedge clk);
    d = bank_diffs();
    n_vec++;
    if (wr_cnt !== w0 || d != 0) begin
      n_err++;
      $display("FAIL len_err_nowrite: writes=%0d bank_diffs=%0d required writes=%0d diffs=0",
               wr_cnt - w0, d, 0);
    end
  endtask

  task automatic test_reset_mid();
    logic rdy; int w0; int seen; int d;
    w0 = wr_cnt; seen = 0;
    for (int i = 0; i < 3; i++) exp_bank[16 + i] = 8'h77;
    send_req(OP_FILL, 5'd16, 5'd0, 6'd8, 8'h77, rdy);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if ({r_w, resp_valid, req_ready, busy} !== 4'b1010) begin
      n_err++;
      $display("FAIL reset_mid_idle: got rw/vld/rdy/busy=%b required 1010",
               {r_w, resp_valid, req_ready, busy});
    end
    repeat (12) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen++;
    end
    d = bank_diffs();
    n_vec++;
    if (wr_cnt - w0 !== 3 || seen !== 0 || d != 0) begin
      n_err++;
      $display("FAIL reset_mid: writes=%0d resps=%0d bank_diffs=%0d required 3 0 0",
               wr_cnt - w0, seen, d);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic err; logic [7:0] rd; logic bok; logic rdy; exp_t e; int d; int seen;
    sb.push_back('{RL + 1, 1'b0, 8'h77});
    send_req(OP_LOAD, 5'd17, 5'd0, 6'd0, 8'h00, rdy);
    wait_resp(lat, err, rd, bok);
    e = sb.pop_front();
    n_vec++;
    if (lat !== e.lat || rd !== e.rdata) begin
      n_err++;
      $display("FAIL load_after_abort: lat=%0d rdata=%h required lat=%0d rdata=%h",
               lat, rd, e.lat, e.rdata);
    end
    // A second request offered while busy must be dropped.
    sb.push_back('{2, 1'b0, 8'h3C});
    exp_bank[21] = 8'h3C;
    send_req(OP_STORE, 5'd21, 5'd0, 6'd0, 8'h3C, rdy);
    n_vec++;
    if (rdy !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_resp: got req_ready=%b required 1", rdy);
    end
    req_valid = 1'b1; req_op = OP_STORE; req_addr = 5'd20; req_wdata = 8'h99;
    wait_resp(lat, err, rd, bok);
    req_valid = 1'b0;
    e = sb.pop_front();
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen++;
    end
    d = bank_diffs();
    n_vec++;
    if (lat !== e.lat || rd !== e.rdata || bok !== 1'b1 || seen != 0 || d != 0) begin
      n_err++;
      $display("FAIL busy_ignore: lat=%0d rdata=%h busy_ok=%b extra_resps=%0d diffs=%0d required %0d %h 1 0 0",
               lat, rd, bok, seen, d, e.lat, e.rdata);
    end
    sb.push_back('{33, 1'b0, 8'hE1});
    for (int i = 0; i < 32; i++) exp_bank[i] = 8'hE1;
    send_req(OP_FILL, 5'd5, 5'd0, 6'd32, 8'hE1, rdy);
    wait_resp(lat, err, rd, bok);
    e = sb.pop_front();
    d = bank_diffs();
    n_vec++;
    if (lat !== e.lat || err !== e.err || rd !== e.rdata || d != 0) begin
      n_err++;
      $display("FAIL fill_len32: lat=%0d err=%b rdata=%h diffs=%0d required lat=%0d err=%b rdata=%h diffs=0",
               lat, err, rd, d, e.lat, e.err, e.rdata);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_fill_wrap();
    test_copy();
    test_len_err();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
